// File: rtl/class_vote_filter_pkg.sv
// Shared constants and types for the classifier vote filter: the disagree code,
// the commit FSM states and the 7-segment glyph table.
package class_vote_filter_pkg;

    localparam logic [3:0] DISAGREE = 4'hF;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } vote_state_t;

    // Bit order {g,f,e,d,c,b,a}, active-high. Entry F is a bare dash (g only).
    localparam logic [6:0] SEG_LUT [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1000000
    };

endpackage

// File: rtl/class_seg_decode.sv
// 4-bit class to 7-segment glyph; purely combinational, blanking is done by the caller.
module class_seg_decode
    import class_vote_filter_pkg::*;
(
    input  logic [3:0] i_class,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_LUT[i_class];

endmodule

// File: rtl/class_vote_filter.sv
// Samples two classifier outputs once per prescaler period and commits a class
// only after STABLE_COUNT consecutive identical samples; disagreement votes as 4'hF.
module class_vote_filter
    import class_vote_filter_pkg::*;
#(
    parameter logic [23:0] MAX_COUNT    = 24'd10_000_000,
    parameter int unsigned STABLE_COUNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] perc_class,
    input  logic [3:0] bnn_class,
    output logic [3:0] out_class,
    output logic       out_valid,
    output logic       locked,
    output logic [6:0] seg
);

    localparam logic [3:0] STABLE = 4'(STABLE_COUNT);

    logic [23:0]  r_presc;
    logic [3:0]   r_run;
    logic [3:0]   r_last_cand;
    logic [3:0]   r_out_class;
    logic         r_out_valid;
    logic         r_committed;
    vote_state_t  r_state;

    logic         w_strobe;
    logic [3:0]   w_cand;
    logic         w_match;
    logic [3:0]   w_run_nxt;
    logic         w_reach;
    logic         w_commit;
    logic [6:0]   w_seg;

    assign w_strobe  = ena && (r_presc == MAX_COUNT - 24'd1);
    assign w_cand    = (perc_class == bnn_class) ? perc_class : DISAGREE;
    assign w_match   = (w_cand == r_last_cand);
    // A mismatch always restarts the run at 1, even when the old run was one short.
    assign w_run_nxt = !w_match ? 4'd1 :
                       (r_run >= STABLE) ? STABLE : r_run + 4'd1;
    assign w_reach   = (w_run_nxt == STABLE);
    // Staying LOCKED on a continued match is not a new commit.
    assign w_commit  = w_strobe && w_reach && !(r_state == LOCKED && w_match);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (ena) begin
            r_presc <= (r_presc == MAX_COUNT - 24'd1) ? '0 : r_presc + 24'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_run       <= '0;
            r_last_cand <= '0;
            r_out_class <= '0;
            r_out_valid <= 1'b0;
            r_committed <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_strobe) begin
                r_run       <= w_run_nxt;
                r_last_cand <= w_cand;
                r_state     <= w_reach ? LOCKED : TRACK;
            end
            if (w_commit) begin
                r_out_class <= w_cand;
                r_out_valid <= !r_committed || (w_cand != r_out_class);
                r_committed <= 1'b1;
            end
        end
    end

    class_seg_decode u_seg (
        .i_class (r_out_class),
        .o_seg   (w_seg)
    );

    assign out_class = r_out_class;
    assign out_valid = r_out_valid;
    assign locked    = (r_state == LOCKED);
    assign seg       = r_committed ? w_seg : 7'b0;

endmodule

// File: tb/tb_class_vote_filter.sv
// Directed bench for class_vote_filter (MAX_COUNT=4, STABLE_COUNT=3) with a commit scoreboard.
module tb_class_vote_filter;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [3:0] perc_class;
    logic [3:0] bnn_class;
    logic [3:0] out_class;
    logic       out_valid;
    logic       locked;
    logic [6:0] seg;

    int n_pass  = 0;
    int n_total = 0;
    logic [3:0] exp_q[$];

    class_vote_filter #(.MAX_COUNT(24'd4), .STABLE_COUNT(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .perc_class (perc_class),
        .bnn_class  (bnn_class),
        .out_class  (out_class),
        .out_valid  (out_valid),
        .locked     (locked),
        .seg        (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One full sample period from a period boundary: the strobe is taken at the 4th edge.
    task automatic period(input logic [3:0] p, input logic [3:0] b);
        perc_class = p;
        bnn_class  = b;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every out_valid pulse must match the next queued commit.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", {28'd0, out_class}, 32'hDEAD);
            end else begin
                chk("commit_class", {28'd0, out_class}, {28'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1; perc_class = 4'h0; bnn_class = 4'h0;
        #12;
        chk("rst_out_class", {28'd0, out_class}, 32'h0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'h0);
        chk("rst_locked",    {31'd0, locked},    32'h0);
        chk("rst_seg",       {25'd0, seg},       32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Steady agreement on 5 commits after the 3rd strobe.
        period(4'h5, 4'h5);
        period(4'h5, 4'h5);
        chk("s5_pre_locked", {31'd0, locked},    32'h0);
        chk("s5_pre_class",  {28'd0, out_class}, 32'h0);
        exp_q.push_back(4'h5);
        period(4'h5, 4'h5);
        chk("s5_valid",  {31'd0, out_valid}, 32'h1);
        chk("s5_class",  {28'd0, out_class}, 32'h5);
        chk("s5_locked", {31'd0, locked},    32'h1);
        chk("s5_seg",    {25'd0, seg},       32'h6D);

        // Disagreement drops lock at once, commits F after three strobes.
        period(4'h5, 4'h7);
        chk("dis_unlock", {31'd0, locked},    32'h0);
        chk("dis_hold",   {28'd0, out_class}, 32'h5);
        period(4'h5, 4'h7);
        exp_q.push_back(4'hF);
        period(4'h5, 4'h7);
        chk("dis_class",  {28'd0, out_class}, 32'hF);
        chk("dis_seg",    {25'd0, seg},       32'h40);
        chk("dis_locked", {31'd0, locked},    32'h1);

        // 2,2,3,2,2,2: the 3 restarts the run.
        period(4'h2, 4'h2);
        period(4'h2, 4'h2);
        period(4'h3, 4'h3);
        period(4'h2, 4'h2);
        period(4'h2, 4'h2);
        chk("run_restart_class",  {28'd0, out_class}, 32'hF);
        chk("run_restart_locked", {31'd0, locked},    32'h0);
        exp_q.push_back(4'h2);
        period(4'h2, 4'h2);
        chk("run_commit_class", {28'd0, out_class}, 32'h2);
        chk("run_commit_seg",   {25'd0, seg},       32'h5B);

        // Lock on 4, glitch to 6, re-lock on 4 silently.
        exp_q.push_back(4'h4);
        repeat (3) period(4'h4, 4'h4);
        chk("l4_class", {28'd0, out_class}, 32'h4);
        period(4'h6, 4'h6);
        chk("glitch_locked", {31'd0, locked},    32'h0);
        chk("glitch_class",  {28'd0, out_class}, 32'h4);
        repeat (3) period(4'h4, 4'h4);
        chk("relock_locked", {31'd0, locked},    32'h1);
        chk("relock_class",  {28'd0, out_class}, 32'h4);
        chk("relock_valid",  {31'd0, out_valid}, 32'h0);

        // Enable gap of 10 cycles after two counts of the period.
        perc_class = 4'h9; bnn_class = 4'h9;
        repeat (2) @(posedge clk);
        #1;
        ena = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("gap_locked", {31'd0, locked},    32'h1);
        chk("gap_class",  {28'd0, out_class}, 32'h4);
        ena = 1'b1;
        @(posedge clk);
        #1;
        chk("gap_no_early", {31'd0, locked}, 32'h1);
        @(posedge clk);
        #1;
        chk("gap_strobe", {31'd0, locked}, 32'h0);
        period(4'h9, 4'h9);
        exp_q.push_back(4'h9);
        period(4'h9, 4'h9);
        chk("gap_commit_class", {28'd0, out_class}, 32'h9);
        chk("gap_commit_seg",   {25'd0, seg},       32'h6F);

        // Asynchronous reset between edges while LOCKED.
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_class",  {28'd0, out_class}, 32'h0);
        chk("arst_locked", {31'd0, locked},    32'h0);
        chk("arst_valid",  {31'd0, out_valid}, 32'h0);
        chk("arst_seg",    {25'd0, seg},       32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        period(4'h9, 4'h9);
        period(4'h9, 4'h9);
        chk("arst_pre_locked", {31'd0, locked}, 32'h0);
        chk("arst_pre_seg",    {25'd0, seg},    32'h0);
        exp_q.push_back(4'h9);
        period(4'h9, 4'h9);
        chk("arst_recommit_class",  {28'd0, out_class}, 32'h9);
        chk("arst_recommit_locked", {31'd0, locked},    32'h1);

        repeat (6) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
